// File: rtl/sha256_pkg.sv
// SHA-256 constants, FSM encoding and the round/schedule helper functions.
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        UPDATE
    } state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, y, z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, y, z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// Sixteen-word rolling message window; word 0 is W[t] for the current round.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [511:0] msg,
    output logic [31:0]  w_t
);

    logic [31:0] win_q [16];
    logic [31:0] win_d [16];

    always_comb begin
        win_d = win_q;
        if (load) begin
            for (int i = 0; i < 16; i++) begin
                win_d[i] = msg[511 - 32*i -: 32];
            end
        end else if (shift) begin
            for (int i = 0; i < 15; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[15] = ssig1(win_q[14]) + win_q[9]
                      + ssig0(win_q[1]) + win_q[0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            win_q <= win_d;
        end
    end

    assign w_t = win_q[0];

endmodule

// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression: one round per cycle, 66 cycles per block.
module sha256_compress
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         final_block,
    input  logic [511:0] msg_padded,
    output logic         done,
    output logic         busy,
    output logic [255:0] digest,
    output logic         digest_valid
);

    state_t       state_q, state_d;
    logic [5:0]   t_q, t_d;
    logic         final_q, final_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;
    logic         dv_q, dv_d;
    logic [255:0] digest_q, digest_d;
    logic [31:0]  v_q [8];
    logic [31:0]  v_d [8];
    logic [31:0]  h_q [8];
    logic [31:0]  h_d [8];
    logic [31:0]  sum [8];
    logic [31:0]  t1, t2, w_t;
    logic         load, shift;

    sha256_msg_sched u_sched (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .msg   (msg_padded),
        .w_t   (w_t)
    );

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        final_d  = final_q;
        digest_d = digest_q;
        v_d      = v_q;
        h_d      = h_q;
        done_d   = 1'b0;
        dv_d     = 1'b0;
        load     = 1'b0;
        shift    = 1'b0;
        t1       = '0;
        t2       = '0;
        for (int i = 0; i < 8; i++) begin
            sum[i] = h_q[i] + v_q[i];
        end
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    load    = 1'b1;
                    final_d = final_block;
                    v_d     = h_q;
                    t_d     = '0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                shift = 1'b1;
                t1 = v_q[7] + bsig1(v_q[4]) + ch(v_q[4], v_q[5], v_q[6])
                   + K[t_q] + w_t;
                t2 = bsig0(v_q[0]) + maj(v_q[0], v_q[1], v_q[2]);
                v_d[7] = v_q[6];
                v_d[6] = v_q[5];
                v_d[5] = v_q[4];
                v_d[4] = v_q[3] + t1;
                v_d[3] = v_q[2];
                v_d[2] = v_q[1];
                v_d[1] = v_q[0];
                v_d[0] = t1 + t2;
                t_d    = t_q + 6'd1;
                if (t_q == 6'd63) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (final_q) begin
                    dv_d = 1'b1;
                    h_d  = IV;
                    for (int i = 0; i < 8; i++) begin
                        digest_d[255 - 32*i -: 32] = sum[i];
                    end
                end else begin
                    h_d = sum;
                end
            end
            default: state_d = IDLE;
        endcase
        // busy stays up through the done cycle even though state is IDLE
        busy_d = (state_d != IDLE) || (state_q == UPDATE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            t_q      <= '0;
            final_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            dv_q     <= 1'b0;
            digest_q <= '0;
            h_q      <= IV;
            for (int i = 0; i < 8; i++) begin
                v_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            final_q  <= final_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            dv_q     <= dv_d;
            digest_q <= digest_d;
            h_q      <= h_d;
            v_q      <= v_d;
        end
    end

    assign done         = done_q;
    assign busy         = busy_q;
    assign digest       = digest_q;
    assign digest_valid = dv_q;

endmodule
